operand_sequencer: RTL

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/alu_pkg.sv | 15 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/operand_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the operand sequencer: default sizing and the
// FSM state encoding, which is also exposed on the LED debug port.
package alu_pkg;

   localparam int DEFAULT_WIDTH     = 6;
   localparam int DEFAULT_DB_CYCLES = 4;

   // Code 2'b11 is deliberately left unassigned; the FSM recovers from it.
   typedef enum logic [1:0] {
      LOAD_X = 2'b00,
      LOAD_Y = 2'b01,
      VALID  = 2'b10
   } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus saturating debounce counter; emits one
// registered pulse per qualified press of a raw asynchronous button.
module btn_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic pulse
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   // The pulse fires on the single step where the count reaches CNT_MAX;
   // saturation afterwards keeps a held button from retriggering.
   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d   = cnt_q + 1'b1;
         pulse_d = (cnt_q == CNT_MAX - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/operand_sequencer.sv
// Collects two operands from the switches on debounced load presses and
// presents them to a downstream consumer with a valid/ready handshake.
module operand_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn_load,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [1:0]       state
);

   logic load_pulse;
   logic clear_pulse;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_load),
      .pulse   (load_pulse)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clear),
      .pulse   (clear_pulse)
   );

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             op_valid_q, op_valid_d;

   // Clear outranks both load and the handshake; sw is only looked at on
   // the edge a load pulse is consumed.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      if (clear_pulse) begin
         state_d = LOAD_X;
         x_d     = '0;
         y_d     = '0;
      end else begin
         case (state_q)
            LOAD_X: begin
               if (load_pulse) begin
                  x_d     = sw;
                  state_d = LOAD_Y;
               end
            end
            LOAD_Y: begin
               if (load_pulse) begin
                  y_d     = sw;
                  state_d = VALID;
               end
            end
            VALID: begin
               if (op_valid_q && op_ready) begin
                  state_d = LOAD_X;
               end
            end
            default: state_d = LOAD_X;
         endcase
      end
      op_valid_d = (state_d == VALID);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD_X;
         x_q        <= '0;
         y_q        <= '0;
         op_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         op_valid_q <= op_valid_d;
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign op_valid = op_valid_q;
   assign state    = state_q;

endmodule
